// File: rtl/pll_loop_ctrl.sv
// Carrier-recovery PLL loop sequencer: issues one datapath update per symbol, captures the
// feedback state, publishes the corrected phase and tracks lock. Optional PLL_FREEZE_EN adds `freeze`.
module pll_loop_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LOCK_THR   = 'h0040,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [WIDTH-1:0] phi_err_in,
  input  logic [WIDTH-1:0] phi_right_in,
  input  logic             loop_clr,
  input  logic             ovr_clr,
`ifdef PLL_FREEZE_EN
  input  logic             freeze,
`endif
  output logic             ready,
  output logic             proc_start,
  output logic [WIDTH-1:0] proc_phi_err,
  output logic [WIDTH-1:0] proc_phi_right,
  output logic [WIDTH-1:0] e_fb,
  output logic [WIDTH-1:0] teta_fb,
  output logic [WIDTH-1:0] phi_fb,
  input  logic [WIDTH-1:0] e_res,
  input  logic [WIDTH-1:0] teta_res,
  input  logic [WIDTH-1:0] phi_res,
  output logic [WIDTH-1:0] phi_corr,
  output logic             phi_corr_valid,
  output logic             locked,
  output logic             overrun
);

  localparam logic [7:0]       LockCnt   = 8'(LOCK_CNT);
  localparam logic [7:0]       UnlockCnt = 8'(UNLOCK_CNT);
  localparam logic [WIDTH-1:0] LockThr   = WIDTH'(LOCK_THR);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StPublish} state_e;

  state_e     state_q;
  logic       start_q;
  logic       valid_q;
  logic       freeze_q;
  logic       freeze_in;
  logic [7:0] hit_q, miss_q;
  logic [7:0] hit_nxt, miss_nxt;
  logic       hit;

`ifdef PLL_FREEZE_EN
  assign freeze_in = freeze;
`else
  assign freeze_in = 1'b0;
`endif

  always_comb begin
    hit      = teta_res < LockThr;
    hit_nxt  = (hit_q == LockCnt) ? hit_q : hit_q + 8'd1;
    miss_nxt = (miss_q == UnlockCnt) ? miss_q : miss_q + 8'd1;
  end

  assign ready = (state_q == StIdle);
  // A clear aborts the in-flight symbol, so its strobes are suppressed in the same cycle.
  assign proc_start     = start_q & ~loop_clr;
  assign phi_corr_valid = valid_q & ~loop_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      start_q        <= 1'b0;
      valid_q        <= 1'b0;
      freeze_q       <= 1'b0;
      proc_phi_err   <= '0;
      proc_phi_right <= '0;
      e_fb           <= '0;
      teta_fb        <= '0;
      phi_fb         <= '0;
      phi_corr       <= '0;
      hit_q          <= '0;
      miss_q         <= '0;
      locked         <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      start_q <= 1'b0;
      valid_q <= 1'b0;
      // Set beats clear when both happen in one cycle.
      if (sym_valid && state_q != StIdle) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
      if (loop_clr) begin
        state_q  <= StIdle;
        e_fb     <= '0;
        teta_fb  <= '0;
        phi_fb   <= '0;
        phi_corr <= '0;
        hit_q    <= '0;
        miss_q   <= '0;
        locked   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (sym_valid) begin
              proc_phi_err   <= phi_err_in;
              proc_phi_right <= phi_right_in;
              freeze_q       <= freeze_in;
              start_q        <= ~freeze_in;
              state_q        <= StIssue;
            end
          end
          StIssue: state_q <= StCapture;
          StCapture: begin
            if (!freeze_q) begin
              e_fb     <= e_res;
              teta_fb  <= teta_res;
              phi_fb   <= phi_res;
              phi_corr <= phi_res;
              if (hit) begin
                hit_q  <= hit_nxt;
                miss_q <= '0;
                if (hit_nxt == LockCnt) locked <= 1'b1;
              end else begin
                miss_q <= miss_nxt;
                hit_q  <= '0;
                if (miss_nxt == UnlockCnt) locked <= 1'b0;
              end
            end
            valid_q <= 1'b1;
            state_q <= StPublish;
          end
          StPublish: state_q <= StIdle;
          default:   state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Self-checking bench for pll_loop_ctrl: directed scenarios plus random traffic against a
// symbol-timeline reference model, with a behavioural loop-filter datapath attached.
module tb_pll_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sym_valid, loop_clr, ovr_clr;
  logic [15:0] phi_err_in, phi_right_in;
  logic        ready, proc_start, phi_corr_valid, locked, overrun;
  logic [15:0] proc_phi_err, proc_phi_right, e_fb, teta_fb, phi_fb, phi_corr;
  logic [15:0] e_res, teta_res, phi_res;
`ifdef PLL_FREEZE_EN
  logic        freeze;
`endif

  always #5 clk = ~clk;

  pll_loop_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sym_valid      (sym_valid),
    .phi_err_in     (phi_err_in),
    .phi_right_in   (phi_right_in),
    .loop_clr       (loop_clr),
    .ovr_clr        (ovr_clr),
`ifdef PLL_FREEZE_EN
    .freeze         (freeze),
`endif
    .ready          (ready),
    .proc_start     (proc_start),
    .proc_phi_err   (proc_phi_err),
    .proc_phi_right (proc_phi_right),
    .e_fb           (e_fb),
    .teta_fb        (teta_fb),
    .phi_fb         (phi_fb),
    .e_res          (e_res),
    .teta_res       (teta_res),
    .phi_res        (phi_res),
    .phi_corr       (phi_corr),
    .phi_corr_valid (phi_corr_valid),
    .locked         (locked),
    .overrun        (overrun)
  );

  // Loop-filter datapath: teta = err - right, e' = e + teta/64 + teta/128, phi' = phi + e'.
  logic [15:0] dp_t, dp_e;
  assign dp_t = proc_phi_err - proc_phi_right;
  assign dp_e = e_fb + (dp_t >> 6) + (dp_t >> 7);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      teta_res <= '0;
      e_res    <= '0;
      phi_res  <= '0;
    end else if (proc_start) begin
      teta_res <= dp_t;
      e_res    <= dp_e;
      phi_res  <= phi_fb + dp_e;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: loop state plus the timeline of the one symbol in flight.
  logic [15:0] m_e, m_teta, m_phi, m_corr, m_perr, m_pright;
  int          m_hit, m_miss, m_acc, cyc;
  bit          m_locked, m_ovr, m_inflight, m_frz;

  task automatic model_reset();
    m_e = 0; m_teta = 0; m_phi = 0; m_corr = 0; m_perr = 0; m_pright = 0;
    m_hit = 0; m_miss = 0; m_locked = 0; m_ovr = 0; m_inflight = 0; m_frz = 0;
  endtask

  task automatic check_all(input bit exp_start, input bit exp_valid, input bit exp_ready);
    check("ready", 32'(ready), 32'(exp_ready));
    check("proc_start", 32'(proc_start), 32'(exp_start));
    check("phi_corr_valid", 32'(phi_corr_valid), 32'(exp_valid));
    check("proc_phi_err", 32'(proc_phi_err), 32'(m_perr));
    check("proc_phi_right", 32'(proc_phi_right), 32'(m_pright));
    check("e_fb", 32'(e_fb), 32'(m_e));
    check("teta_fb", 32'(teta_fb), 32'(m_teta));
    check("phi_fb", 32'(phi_fb), 32'(m_phi));
    check("phi_corr", 32'(phi_corr), 32'(m_corr));
    check("locked", 32'(locked), 32'(m_locked));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model across the edge.
  task automatic step(input bit sv, input logic [15:0] err, input logic [15:0] right,
                      input bit lclr, input bit oclr, input bit frz);
    int  ph;
    bit  busy;
    logic [15:0] t;
    @(negedge clk);
    sym_valid = sv; phi_err_in = err; phi_right_in = right; loop_clr = lclr; ovr_clr = oclr;
`ifdef PLL_FREEZE_EN
    freeze = frz;
`endif
    #1;
    ph   = cyc - m_acc;
    busy = m_inflight && ph >= 1 && ph <= 3;
    check_all(busy && ph == 1 && !m_frz && !lclr, busy && ph == 3 && !lclr, !busy);
    if (sv && busy) m_ovr = 1;
    else if (oclr) m_ovr = 0;
    if (lclr) begin
      m_inflight = 0; m_e = 0; m_teta = 0; m_phi = 0; m_corr = 0;
      m_hit = 0; m_miss = 0; m_locked = 0;
    end else begin
      if (busy && ph == 2 && !m_frz) begin
        t = m_perr - m_pright;
        m_e = m_e + (t >> 6) + (t >> 7);
        m_phi = m_phi + m_e;
        m_teta = t;
        m_corr = m_phi;
        if (t < 16'h0040) begin
          m_miss = 0; m_hit = (m_hit < 4) ? m_hit + 1 : 4;
          if (m_hit == 4) m_locked = 1;
        end else begin
          m_hit = 0; m_miss = (m_miss < 8) ? m_miss + 1 : 8;
          if (m_miss == 8) m_locked = 0;
        end
      end
      if (busy && ph == 3) m_inflight = 0;
      if (sv && !busy) begin
        m_inflight = 1; m_acc = cyc; m_perr = err; m_pright = right;
`ifdef PLL_FREEZE_EN
        m_frz = frz;
`else
        m_frz = 0;
`endif
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 16'h0, 0, 0, 0);
  endtask

  task automatic sym(input logic [15:0] err, input logic [15:0] right, input bit frz);
    step(1, err, right, 0, 0, frz);
    idle(3);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    sym_valid = 0; loop_clr = 0; ovr_clr = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all(0, 0, 1);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; sym_valid = 0; loop_clr = 0; ovr_clr = 0; phi_err_in = 0; phi_right_in = 0;
`ifdef PLL_FREEZE_EN
    freeze = 0;
`endif
    cyc = 0; m_acc = -100;
    model_reset();
    repeat (2) @(negedge clk);
    check_all(0, 0, 1);
    rst_n = 1;

    idle(10);

    // First symbol through the datapath.
    step(1, 16'h0100, 16'h0000, 0, 0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 0);
    check("dir_start", 32'(proc_start), 32'h1);
    check("dir_phi_err", 32'(proc_phi_err), 32'h0100);
    check("dir_e_fb_pre", 32'(e_fb), 32'h0);
    idle(2);
    check("dir_valid", 32'(phi_corr_valid), 32'h1);
    check("dir_phi_corr", 32'(phi_corr), 32'h0006);
    check("dir_e_fb", 32'(e_fb), 32'h0006);
    check("dir_teta_fb", 32'(teta_fb), 32'h0100);
    idle(1);

    // Overrun: second strobe two cycles after the first is dropped.
    step(1, 16'h0020, 16'h0000, 0, 0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 0);
    step(1, 16'h0777, 16'h0000, 0, 0, 0);
    idle(2);
    check("ovr_set", 32'(overrun), 32'h1);
    step(0, 16'h0, 16'h0, 0, 1, 0);
    idle(1);
    check("ovr_clr", 32'(overrun), 32'h0);

    // Lock acquisition and loss.
    step(0, 16'h0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) sym(16'h0510, 16'h0500, 0);
    check("lock_3hits", 32'(locked), 32'h0);
    sym(16'h0510, 16'h0500, 0);
    check("lock_4hits", 32'(locked), 32'h1);
    for (int i = 0; i < 7; i++) sym(16'h0100, 16'h0000, 0);
    check("lock_7miss", 32'(locked), 32'h1);
    sym(16'h0100, 16'h0000, 0);
    check("lock_8miss", 32'(locked), 32'h0);

    // Abort in ISSUE.
    step(1, 16'h0200, 16'h0000, 0, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);
    idle(1);
    check("clr_ready", 32'(ready), 32'h1);
    check("clr_phi_corr", 32'(phi_corr), 32'h0);
    check("clr_e_fb", 32'(e_fb), 32'h0);
    idle(3);

`ifdef PLL_FREEZE_EN
    for (int i = 0; i < 4; i++) sym(16'h0003, 16'h0000, 0);
    check("frz_locked_pre", 32'(locked), 32'h1);
    sym(16'h0900, 16'h0000, 1);
    check("frz_locked", 32'(locked), 32'h1);
    check("frz_teta", 32'(teta_fb), 32'h0003);
`endif

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          sv, lc, oc, fz;
      logic [15:0] r, e;
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else begin
        lc = ($urandom_range(0, 39) == 0);
        sv = !lc && ($urandom_range(0, 2) == 0);
        oc = !lc && ($urandom_range(0, 9) == 0);
        fz = ($urandom_range(0, 4) == 0);
        r  = 16'($urandom);
        e  = ($urandom_range(0, 1) == 0) ? r + 16'($urandom_range(0, 16'h7f)) : 16'($urandom);
        step(sv, e, r, lc, oc, fz);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
